// File: rtl/pe_pkg.sv
// pe_pkg: shared fixed-point widths, types and saturation helper for the PE array paths.
package pe_pkg;
  localparam int IW = 24;
  localparam int FW = 8;
  localparam int DW = IW + FW;
  localparam int GUARD = 8;
  localparam int ACC_W = DW + GUARD;
  localparam int LANES = 7;
  typedef logic signed [DW-1:0] word_t;
  typedef logic signed [ACC_W-1:0] acc_t;
  typedef enum logic {ACC, OUT} state_t;
  localparam word_t SAT_MAX = 32'h7FFF_FFFF;
  localparam word_t SAT_MIN = 32'h8000_0000;
  function automatic word_t sat_dw(input logic signed [ACC_W:0] v);
    return (&v[ACC_W:DW-1] || ~|v[ACC_W:DW-1]) ? v[DW-1:0] : (v[ACC_W] ? SAT_MIN : SAT_MAX);
  endfunction
endpackage

// File: rtl/psum_lane_post.sv
// psum_lane_post: per-lane bias add, saturation to DW bits and optional ReLU.
module psum_lane_post #(
  parameter int DW = pe_pkg::DW,
  parameter int ACC_W = pe_pkg::ACC_W,
  parameter bit RELU_EN = 1'b1
) (
  input  logic [ACC_W-1:0] acc,
  input  logic [DW-1:0]    bias,
  output logic [DW-1:0]    res
);
  logic [ACC_W:0] sum;
  logic [DW-1:0]  sat;
  always_comb begin
    sum = {acc[ACC_W-1], acc} + {{(ACC_W+1-DW){bias[DW-1]}}, bias};
    // in range only when every bit above the DW sign bit matches it
    sat = (&sum[ACC_W:DW-1] || ~|sum[ACC_W:DW-1]) ? sum[DW-1:0] : {sum[ACC_W], {(DW-1){~sum[ACC_W]}}};
    res = (RELU_EN && sat[DW-1]) ? '0 : sat;
  end
endmodule

// File: rtl/psum_acc1x1.sv
// psum_acc1x1: accumulates 1x1 PE products across input channels, adds bias, saturates,
// applies ReLU and hands LANES results downstream over valid/ready.
module psum_acc1x1 #(
  parameter int LANES = pe_pkg::LANES,
  parameter int IW = 24,
  parameter int FW = 8,
  parameter int GUARD = 8,
  parameter int MAX_BEATS = 512,
  parameter int RELU_EN = 1,
  localparam int DW = IW + FW,
  localparam int ACC_W = DW + GUARD,
  localparam int CW = $clog2(MAX_BEATS + 1)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [LANES*DW-1:0] psum_i,
  input  logic                in_last,
  input  logic [DW-1:0]       bias_i,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [LANES*DW-1:0] res_o,
  output logic [CW-1:0]       beat_cnt_o,
  output logic                ovf_o
);
  pe_pkg::state_t state, state_nx;
  logic                first;
  logic [ACC_W-1:0]    acc [LANES];
  logic [ACC_W-1:0]    acc_nx [LANES];
  logic [DW-1:0]       bias_r, bias_sel;
  logic [LANES*DW-1:0] post;
  logic [CW-1:0]       cnt_nx;
  logic                take, hit, done;

  assign take = in_valid && in_ready;
  assign cnt_nx = first ? CW'(1) : beat_cnt_o + CW'(1);
  assign hit = cnt_nx == CW'(MAX_BEATS);
  assign done = take && (in_last || hit);
  // a single-beat group must see this beat's bias, not the stale register
  assign bias_sel = first ? bias_i : bias_r;

  for (genvar k = 0; k < LANES; k++) begin : g_lane
    logic [ACC_W-1:0] ext;
    assign ext = {{GUARD{psum_i[k*DW+DW-1]}}, psum_i[k*DW +: DW]};
    assign acc_nx[k] = first ? ext : acc[k] + ext;
    psum_lane_post #(.DW(DW), .ACC_W(ACC_W), .RELU_EN(RELU_EN != 0)) u_post (
      .acc(acc_nx[k]),
      .bias(bias_sel),
      .res(post[k*DW +: DW])
    );
  end

  always_comb begin
    state_nx = state;
    in_ready = state == pe_pkg::ACC;
    out_valid = state == pe_pkg::OUT;
    if (in_ready && done) state_nx = pe_pkg::OUT;
    if (out_valid && out_ready) state_nx = pe_pkg::ACC;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= pe_pkg::ACC;
      first <= 1'b1;
      for (int i = 0; i < LANES; i++) acc[i] <= '0;
      bias_r <= '0;
      res_o <= '0;
      beat_cnt_o <= '0;
      ovf_o <= 1'b0;
    end else begin
      state <= state_nx;
      if (take) begin
        for (int i = 0; i < LANES; i++) acc[i] <= acc_nx[i];
        bias_r <= bias_sel;
        beat_cnt_o <= cnt_nx;
        first <= 1'b0;
      end
      if (done) res_o <= post;
      if (take && hit && !in_last) ovf_o <= 1'b1;
      if (out_valid && out_ready) begin
        first <= 1'b1;
        beat_cnt_o <= '0;
      end
    end
  end
endmodule

// File: tb/tb_psum_acc1x1.sv
// tb_psum_acc1x1: directed checks of psum_acc1x1 in ReLU, no-ReLU and MAX_BEATS=4 builds.
module tb_psum_acc1x1;
  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         in_valid = 1'b0;
  logic         in_last = 1'b0;
  logic         out_ready = 1'b0;
  logic [223:0] psum = '0;
  logic [31:0]  bias = '0;
  logic         rdy [3];
  logic         vld [3];
  logic         ovf [3];
  logic [223:0] res [3];
  logic [9:0]   cnt0, cnt1;
  logic [2:0]   cnt2;
  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  psum_acc1x1 dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(rdy[0]), .psum_i(psum),
    .in_last(in_last), .bias_i(bias), .out_valid(vld[0]), .out_ready(out_ready),
    .res_o(res[0]), .beat_cnt_o(cnt0), .ovf_o(ovf[0])
  );
  psum_acc1x1 #(.RELU_EN(0)) dut_nr (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(rdy[1]), .psum_i(psum),
    .in_last(in_last), .bias_i(bias), .out_valid(vld[1]), .out_ready(out_ready),
    .res_o(res[1]), .beat_cnt_o(cnt1), .ovf_o(ovf[1])
  );
  psum_acc1x1 #(.MAX_BEATS(4)) dut_m4 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(rdy[2]), .psum_i(psum),
    .in_last(in_last), .bias_i(bias), .out_valid(vld[2]), .out_ready(out_ready),
    .res_o(res[2]), .beat_cnt_o(cnt2), .ovf_o(ovf[2])
  );

  task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [223:0] fill(input logic [31:0] v);
    return {7{v}};
  endfunction

  task automatic beat(input logic [223:0] p, input logic [31:0] b, input logic l);
    in_valid = 1'b1;
    psum = p;
    bias = b;
    in_last = l;
    @(negedge clk);
    in_valid = 1'b0;
    in_last = 1'b0;
  endtask

  task automatic handshake();
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    check("back_to_acc_rdy", rdy[0], 1'b1);
    check("back_to_acc_vld", vld[0], 1'b0);
    check("back_to_acc_cnt", cnt0, 10'd0);
  endtask

  initial begin
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("rst_rdy", rdy[0], 1'b1);
    check("rst_vld", vld[0], 1'b0);
    check("rst_res", res[0], '0);
    check("rst_ovf", ovf[0], 1'b0);
    check("rst_cnt", cnt0, 10'd0);

    for (int i = 0; i < 3; i++) beat(fill(32'h100), 32'h80, i == 2);
    check("sum3_vld", vld[0], 1'b1);
    check("sum3_rdy", rdy[0], 1'b0);
    check("sum3_res", res[0], fill(32'h380));
    check("sum3_cnt", cnt0, 10'd3);
    handshake();

    for (int i = 0; i < 4; i++)
      beat(i < 2 ? {160'h0, 32'h8000_0000, 32'h7FFF_0000} : {160'h0, 32'h0, 32'h7FFF_0000}, 32'h0, i == 3);
    check("sat_relu_res", res[0], {160'h0, 32'h0, 32'h7FFF_FFFF});
    check("sat_norelu_res", res[1], {160'h0, 32'h8000_0000, 32'h7FFF_FFFF});
    check("sat_m4_res", res[2], {160'h0, 32'h0, 32'h7FFF_FFFF});
    check("last_at_max_no_ovf", ovf[2], 1'b0);
    handshake();

    for (int i = 0; i < 2; i++) beat(fill(32'h10), 32'h0, i == 1);
    in_valid = 1'b1;
    psum = fill(32'h5);
    in_last = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("bp_res", res[0], fill(32'h20));
      check("bp_rdy", rdy[0], 1'b0);
      check("bp_cnt", cnt0, 10'd2);
    end
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    check("bp_hs_no_beat_cnt", cnt0, 10'd0);
    check("bp_hs_vld", vld[0], 1'b0);
    @(negedge clk);
    in_valid = 1'b0;
    in_last = 1'b0;
    check("bp_next_vld", vld[0], 1'b1);
    check("bp_next_res", res[0], fill(32'h5));
    check("bp_next_cnt", cnt0, 10'd1);
    handshake();

    beat(fill(32'hFFFF_FF00), 32'h300, 1'b1);
    check("single_vld", vld[0], 1'b1);
    check("single_res", res[0], fill(32'h200));
    check("single_cnt", cnt0, 10'd1);
    handshake();

    for (int i = 0; i < 4; i++) beat(fill(32'h1), 32'h0, 1'b0);
    check("m4_vld", vld[2], 1'b1);
    check("m4_ovf", ovf[2], 1'b1);
    check("m4_res", res[2], fill(32'h4));
    check("m4_cnt", cnt2, 3'd4);
    check("main_open_vld", vld[0], 1'b0);
    check("main_open_cnt", cnt0, 10'd4);
    check("main_open_ovf", ovf[0], 1'b0);
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    check("ready_in_acc_cnt", cnt0, 10'd4);
    check("m4_ovf_sticky", ovf[2], 1'b1);
    beat(fill(32'h7), 32'h0, 1'b0);
    check("m4_new_cnt", cnt2, 3'd1);
    #2 rst = 1'b1;
    #1;
    check("arst_ovf", ovf[2], 1'b0);
    check("arst_cnt", cnt2, 3'd0);
    check("arst_main_cnt", cnt0, 10'd0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    beat(fill(32'h40), 32'h10, 1'b1);
    check("post_rst_res", res[0], fill(32'h50));
    check("post_rst_m4_res", res[2], fill(32'h50));
    check("post_rst_m4_ovf", ovf[2], 1'b0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
